param_inst_mem: RTL and testbench
=================================

PARAM_INST_MEM -- requirements
Module: param_inst_mem

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width in bits.
REQ-002 Parameter DEPTH, default 256, number of words; ADDR_W = clog2(DEPTH).
REQ-003 Parameter FILL, default all-ones of DATA_W (16'hFFFF), the NOP/erased value.
REQ-004 Parameter HALT_ADDR, default DEPTH-1, the fetch address that stops the block.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ld_valid  in  1  load word offered.
REQ-009 ld_data  in  DATA_W  load word.
REQ-010 ld_last  in  1  qualifies the final load word.
REQ-011 ld_ready  out  1  block accepts load words.
REQ-012 ld_count  out  ADDR_W+1  number of words loaded.
REQ-013 rd_en  in  1  fetch request.
REQ-014 i_dir  in  32  fetch address.
REQ-015 o_dir  out  DATA_W  fetched instruction.
REQ-016 o_valid  out  1  o_dir updated this cycle.
REQ-017 busy  out  1  high in INIT and LOAD.
REQ-018 done  out  1  sticky halt flag.

Function
REQ-019 The FSM SHALL have the states INIT, LOAD, RUN and HALT, and SHALL enter INIT on rst.
REQ-020 INIT: writes FILL to addresses 0..DEPTH-1, one per cycle, then moves to LOAD after exactly DEPTH cycles; ld_ready=0, o_valid=0.
REQ-021 LOAD: ld_ready=1; each ld_valid&&ld_ready cycle writes ld_data at the load pointer (starting at 0), increments the pointer and ld_count.
REQ-022 LOAD exits to RUN on the cycle after an accepted word with ld_last=1, or after the word written at DEPTH-1; ld_ready drops in that same next cycle.
REQ-023 In LOAD, ld_valid=0 SHALL leave the pointer unchanged; unwritten addresses keep FILL.
REQ-024 RUN: rd_en samples i_dir; on the next edge o_dir=mem[i_dir] and o_valid=1 for one cycle; the read has 1-cycle latency and back-to-back fetches are allowed every cycle.
REQ-025 An i_dir >= DEPTH SHALL return FILL, and SHALL NOT wrap or alias.
REQ-026 A fetch with i_dir==HALT_ADDR SHALL return its word normally, then the FSM enters HALT and done=1 in the same cycle as that o_valid.
REQ-027 HALT: o_dir holds its last value; rd_en, ld_valid and ld_last are ignored; o_valid=0; only rst leaves HALT.
REQ-028 rd_en outside RUN SHALL be ignored (no o_valid).
REQ-029 ld_valid outside LOAD SHALL be ignored.
REQ-030 When none of REQ-024..REQ-027 applies, o_dir SHALL hold its previous value.

Reset
REQ-031 On rst, in any state and mid-transfer: o_dir=FILL, o_valid=0, ld_ready=0, ld_count=0, busy=1, done=0, state=INIT; the memory is re-filled by INIT.
REQ-032 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-033 The package inst_mem_pkg SHALL hold the state enum, the default FILL constant and the default DATA_W/DEPTH values.
REQ-034 Storage SHALL be a sub-module inst_mem_ram: single-port synchronous RAM, DATA_W x DEPTH, with one write or one read per cycle.
REQ-035 INIT, LOAD and RUN accesses SHALL be mutually exclusive, so one port suffices.

Verification
REQ-036 Reset release -> busy=1, ld_ready=0 for 256 cycles, then ld_ready=1; o_dir=16'hFFFF.
REQ-037 Load 16'hB300, 16'hB200, 16'h8B11 (last) with one idle cycle in between -> ld_count=3, RUN; fetch addresses 0..3 -> 16'hB300, 16'hB200, 16'h8B11, 16'hFFFF at 1-cycle latency, o_valid each cycle.
REQ-038 Fetch i_dir=32'h0000_0100 and 32'hFFFF_FFFF -> o_dir=16'hFFFF.
REQ-039 Fetch 255 -> mem[255] returned with done=1; later fetch of 0 -> no o_valid, o_dir unchanged.
REQ-040 Load 256 words without ld_last -> RUN after word 255, ld_count=256; ld_valid afterwards is ignored.
REQ-041 rst asserted mid-LOAD after 5 words -> INIT; after re-init and an empty load (ld_last on word 0 = 16'h0001), address 4 reads 16'hFFFF.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared types and default parameters for the parameterised instruction memory.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 256;
  localparam logic [DATA_W_DEF-1:0] FILL_DEF = '1;

endpackage

// File: rtl/param_inst_mem_if.sv
// Load channel, fetch channel and status flags of the instruction memory.
interface param_inst_mem_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              rd_en;
  logic [31:0]       i_dir;
  logic [DATA_W-1:0] o_dir;
  logic              o_valid;
  logic              busy;
  logic              done;

  modport master (
    output ld_valid, ld_data, ld_last, rd_en, i_dir,
    input  ld_ready, ld_count, o_dir, o_valid, busy, done
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, rd_en, i_dir,
    output ld_ready, ld_count, o_dir, o_valid, busy, done
  );
endinterface

// File: rtl/inst_mem_ram.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
module inst_mem_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_inst_mem.sv
// Instruction memory: fills itself with FILL, accepts a program load, then
// serves 1-cycle-latency fetches until the halt address is fetched.
module param_inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0] FILL = (DATA_W == DATA_W_DEF) ? DATA_W'(FILL_DEF) : '1,
  parameter int unsigned HALT_ADDR = DEPTH - 1
) (
  input  logic clk,
  input  logic rst,
  param_inst_mem_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovalid_q, ovalid_d;
  logic              oob_q, oob_d;
  logic [DATA_W-1:0] odir_q;
  logic [DATA_W-1:0] odir;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              fetch_oob;

  assign fetch_oob = (bus.i_dir >= 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      count_q  <= '0;
      ovalid_q <= 1'b0;
      oob_q    <= 1'b0;
      odir_q   <= FILL;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      ovalid_q <= ovalid_d;
      oob_q    <= oob_d;
      odir_q   <= odir;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    ovalid_d    = 1'b0;
    oob_d       = oob_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = ptr_q;
    ram_wdata   = FILL;
    bus.ld_ready = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bus.ld_ready = 1'b1;
        ram_addr     = count_q[ADDR_W-1:0];
        ram_wdata    = bus.ld_data;
        if (bus.ld_valid) begin
          ram_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (bus.ld_last || (count_q == LAST_CNT)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        ram_addr = bus.i_dir[ADDR_W-1:0];
        if (bus.rd_en) begin
          ovalid_d = 1'b1;
          oob_d    = fetch_oob;
          ram_re   = !fetch_oob;
          if (bus.i_dir == 32'(HALT_ADDR)) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // RAM data is only meaningful the cycle after a fetch; otherwise show the held word.
  always_comb begin
    odir = odir_q;
    if (ovalid_q) begin
      odir = oob_q ? FILL : ram_rdata;
    end
  end

  inst_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we && !rst),
    .re_i    (ram_re && !rst),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.o_dir    = odir;
  assign bus.o_valid  = ovalid_q;
  assign bus.ld_count = count_q;
  assign bus.busy     = (state_q == ST_INIT) || (state_q == ST_LOAD);
  assign bus.done     = (state_q == ST_HALT);

endmodule

// File: tb/tb_param_inst_mem.sv
// Directed bench for param_inst_mem: init length, load, fetch, range, halt, reset.
module tb_param_inst_mem;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  param_inst_mem_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  param_inst_mem #(
    .DATA_W    (16),
    .DEPTH     (256),
    .FILL      (16'hFFFF),
    .HALT_ADDR (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.rd_en    = 1'b0;
    bus.i_dir    = '0;
  endtask

  // Holds rd_en high through INIT to show fetches there are ignored.
  task automatic wait_init();
    int busy_cycles = 0;
    int stray_valid = 0;
    bus.rd_en = 1'b1;
    bus.i_dir = 32'd0;
    for (int i = 0; i < 256; i++) begin
      if (!bus.ld_ready && bus.busy) busy_cycles++;
      tick();
      if (bus.o_valid) stray_valid++;
    end
    bus.rd_en = 1'b0;
    chk("init_busy_cycles", 32'(busy_cycles), 32'd256);
    chk("init_no_ovalid", 32'(stray_valid), 32'd0);
    chk("init_ld_ready_up", {31'd0, bus.ld_ready}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input string tag,
                       input logic [15:0] exp, input logic exp_done);
    bus.rd_en = 1'b1;
    bus.i_dir = addr;
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, bus.o_dir}, {16'd0, exp});
    chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, exp_done});
  endtask

  logic [15:0] prog [4];

  initial begin
    prog[0] = 16'hB300;
    prog[1] = 16'hB200;
    prog[2] = 16'h8B11;
    prog[3] = 16'hFFFF;
    idle_inputs();

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_o_dir", {16'd0, bus.o_dir}, 32'h0000FFFF);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_count", {23'd0, bus.ld_count}, 32'd0);
    rst = 1'b0;
    wait_init();

    // three-word load with idle gaps; a fetch during LOAD must be ignored
    bus.ld_valid = 1'b1; bus.ld_data = 16'hB300; tick();
    bus.ld_valid = 1'b0; bus.rd_en = 1'b1; tick();
    bus.rd_en = 1'b0;
    chk("load_no_ovalid", {31'd0, bus.o_valid}, 32'd0);
    bus.ld_valid = 1'b1; bus.ld_data = 16'hB200; tick();
    bus.ld_valid = 1'b0; tick();
    bus.ld_valid = 1'b1; bus.ld_data = 16'h8B11; bus.ld_last = 1'b1; tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("load3_count", {23'd0, bus.ld_count}, 32'd3);
    chk("load3_ready_low", {31'd0, bus.ld_ready}, 32'd0);
    chk("load3_busy_low", {31'd0, bus.busy}, 32'd0);

    // back-to-back fetches of 0..3
    bus.rd_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.i_dir = 32'(a);
      tick();
      chk($sformatf("b2b%0d_valid", a), {31'd0, bus.o_valid}, 32'd1);
      chk($sformatf("b2b%0d_data", a), {16'd0, bus.o_dir}, {16'd0, prog[a]});
    end
    bus.rd_en = 1'b0;

    fetch(32'd0, "f0", 16'hB300, 1'b0);
    tick();
    chk("hold_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("hold_data", {16'd0, bus.o_dir}, 32'h0000B300);

    // out-of-range fetches must not alias onto low addresses or the halt address
    fetch(32'h0000_0100, "oob100", 16'hFFFF, 1'b0);
    fetch(32'd2, "f2", 16'h8B11, 1'b0);
    fetch(32'hFFFF_FFFF, "oobmax", 16'hFFFF, 1'b0);

    // halt
    fetch(32'd1, "f1", 16'hB200, 1'b0);
    fetch(32'd255, "halt", 16'hFFFF, 1'b1);
    bus.rd_en = 1'b1; bus.i_dir = 32'd0;
    bus.ld_valid = 1'b1; bus.ld_data = 16'h1234;
    tick();
    idle_inputs();
    chk("halt_no_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("halt_hold", {16'd0, bus.o_dir}, 32'h0000FFFF);
    chk("halt_sticky", {31'd0, bus.done}, 32'd1);
    chk("halt_count", {23'd0, bus.ld_count}, 32'd3);

    // full 256-word load without ld_last
    rst = 1'b1; tick(); rst = 1'b0;
    wait_init();
    for (int i = 0; i < 256; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'(32'h1000 + i);
      tick();
    end
    chk("full_count", {23'd0, bus.ld_count}, 32'd256);
    chk("full_ready_low", {31'd0, bus.ld_ready}, 32'd0);
    bus.ld_data = 16'hDEAD;
    tick();
    tick();
    bus.ld_valid = 1'b0;
    chk("full_extra_ignored", {23'd0, bus.ld_count}, 32'd256);
    fetch(32'd0, "full0", 16'h1000, 1'b0);
    fetch(32'd5, "full5", 16'h1005, 1'b0);
    fetch(32'd254, "full254", 16'h10FE, 1'b0);
    fetch(32'd255, "full255", 16'h10FF, 1'b1);

    // reset mid-load, with ld_valid asserted in the reset cycle
    rst = 1'b1; tick(); rst = 1'b0;
    wait_init();
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'(32'hA000 + i);
      tick();
    end
    chk("mid_count5", {23'd0, bus.ld_count}, 32'd5);
    rst = 1'b1;
    bus.ld_data = 16'hA005;
    tick();
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    chk("mid_rst_count", {23'd0, bus.ld_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("mid_rst_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("mid_rst_o_dir", {16'd0, bus.o_dir}, 32'h0000FFFF);
    wait_init();
    bus.ld_valid = 1'b1; bus.ld_data = 16'h0001; bus.ld_last = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("empty_count", {23'd0, bus.ld_count}, 32'd1);
    fetch(32'd0, "empty0", 16'h0001, 1'b0);
    fetch(32'd4, "refill4", 16'hFFFF, 1'b0);
    fetch(32'd3, "refill3", 16'hFFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
